// File: rtl/plic_claim_agent.sv
// PLIC claim/complete agent: claims one interrupt at a time, hands it to a consumer, completes it.
// Optional service watchdog enabled by defining PLIC_CLAIM_TIMEOUT_EN.
module plic_claim_agent #(
  parameter int SOURCES        = 8,
  parameter int SOURCES_BITS   = 3,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_BITS       = 16
) (
  input  logic                    rst_n,
  input  logic                    clk,
  input  logic                    ireq,
  input  logic [SOURCES_BITS-1:0] id,
  output logic                    claim,
  output logic                    complete,
  output logic                    irq_valid,
  output logic [SOURCES_BITS-1:0] irq_id,
  input  logic                    irq_ready,
  input  logic                    done,
  output logic                    busy,
  output logic                    timeout,
  output logic [CNT_BITS-1:0]     serviced
);

  if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 15 || SOURCES > (1 << SOURCES_BITS) ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("plic_claim_agent: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLAIM,
    DISPATCH,
    SERVICE,
    COMPLETE,
    HOLDOFF
  } state_t;

  localparam logic [3:0] HO_LAST = 4'(HOLDOFF_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       req_ok;
  logic [3:0] ho_cnt;
  logic       wd_fire;

  assign req_ok = ireq && (id != '0);

`ifdef PLIC_CLAIM_TIMEOUT_EN
  localparam int WD_BITS = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

  logic [WD_BITS-1:0] wd_cnt;
  logic               timed_out;

  // done on the limit cycle wins, so the watchdog only fires when done is absent
  assign wd_fire = (state == SERVICE) && !done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state != SERVICE) wd_cnt <= '0;
      else                  wd_cnt <= wd_cnt + 1'b1;
      timed_out <= wd_fire;
    end
  end

  assign timeout = timed_out;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    claim     = 1'b0;
    complete  = 1'b0;
    irq_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (req_ok) state_nxt = CLAIM;
      end
      CLAIM: begin
        claim     = req_ok;
        state_nxt = req_ok ? DISPATCH : IDLE;
      end
      DISPATCH: begin
        irq_valid = 1'b1;
        if (irq_ready) state_nxt = SERVICE;
      end
      SERVICE: begin
        if (done || wd_fire) state_nxt = COMPLETE;
      end
      COMPLETE: begin
        complete  = 1'b1;
        state_nxt = HOLDOFF;
      end
      HOLDOFF: begin
        if (ho_cnt == HO_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ho_cnt   <= '0;
      irq_id   <= '0;
      serviced <= '0;
    end else begin
      if (state != HOLDOFF) ho_cnt <= '0;
      else                  ho_cnt <= ho_cnt + 1'b1;
      if (claim)             irq_id   <= id;
      if (state == COMPLETE) serviced <= serviced + 1'b1;
    end
  end

endmodule

// File: tb/tb_plic_claim_agent.sv
// Self-checking bench for plic_claim_agent; expectations come from per-transaction cycle arithmetic.
module tb_plic_claim_agent;

  localparam int H  = 2;
  localparam int TO = 8;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ireq;
  logic [2:0]    id;
  logic          claim;
  logic          complete;
  logic          irq_valid;
  logic [2:0]    irq_id;
  logic          irq_ready;
  logic          done;
  logic          busy;
  logic          timeout;
  logic [CB-1:0] serviced;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_serv = 0;
  logic [2:0] exp_id = 3'd0;

  plic_claim_agent #(
    .SOURCES(8),
    .SOURCES_BITS(3),
    .HOLDOFF_CYCLES(H),
    .TIMEOUT_CYCLES(TO),
    .CNT_BITS(CB)
  ) dut (
    .rst_n(rst_n),
    .clk(clk),
    .ireq(ireq),
    .id(id),
    .claim(claim),
    .complete(complete),
    .irq_valid(irq_valid),
    .irq_id(irq_id),
    .irq_ready(irq_ready),
    .done(done),
    .busy(busy),
    .timeout(timeout),
    .serviced(serviced)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0; ireq = 1'b1; id = 3'd5; irq_ready = 1'b1; done = 1'b1;
    @(negedge clk);
    obs = {claim, irq_valid, complete, busy, timeout};
    n_cmp++;
    if (obs !== 5'b0) begin n_bad++; $display("FAIL reset_outputs: got %b want 00000", obs); end
    n_cmp++;
    if (irq_id !== 3'd0) begin n_bad++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
    n_cmp++;
    if (serviced !== '0) begin n_bad++; $display("FAIL reset_serviced: got %0d want 0", serviced); end
    ireq = 1'b0; id = 3'd0; irq_ready = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_serv = 0; exp_id = 3'd0;
  endtask

  // ireq/id=5 at 0, ready at 3, done at 6: claim 1, valid 2-3, complete 7, idle 10
  task automatic test_directed();
    logic [4:0] tbl [11];
    logic [4:0] obs;
    logic [2:0] eid;
    int         es;
    tbl = '{5'b00000, 5'b10010, 5'b01010, 5'b01010, 5'b00010, 5'b00010,
            5'b00010, 5'b00110, 5'b00010, 5'b00010, 5'b00000};
    for (int c = 0; c <= 10; c++) begin
      ireq = (c <= 1); id = (c <= 1) ? 3'd5 : 3'd0;
      irq_ready = (c == 3); done = (c == 6);
      @(negedge clk);
      obs = {claim, irq_valid, complete, busy, timeout};
      eid = (c >= 2) ? 3'd5 : exp_id;
      es  = (c >= 8) ? exp_serv + 1 : exp_serv;
      n_cmp++;
      if (obs !== tbl[c]) begin n_bad++; $display("FAIL directed_ctl c=%0d: got %b want %b", c, obs, tbl[c]); end
      n_cmp++;
      if (irq_id !== eid) begin n_bad++; $display("FAIL directed_id c=%0d: got %0d want %0d", c, irq_id, eid); end
      n_cmp++;
      if (serviced !== CB'(es)) begin n_bad++; $display("FAIL directed_serviced c=%0d: got %0d want %0d", c, serviced, CB'(es)); end
      @(posedge clk); #1;
    end
    exp_id = 3'd5; exp_serv++;
  endtask

  task automatic test_withdraw();
    logic [4:0] obs;
    logic [4:0] want;
    for (int v = 0; v < 2; v++) begin
      for (int c = 0; c <= 2; c++) begin
        irq_ready = 1'b1; done = 1'b1;
        if (c == 0) begin ireq = 1'b1; id = 3'd3; end
        else if (c == 1) begin ireq = (v == 1); id = 3'd0; end
        else begin ireq = 1'b0; id = 3'd3; end
        @(negedge clk);
        obs  = {claim, irq_valid, complete, busy, timeout};
        want = (c == 1) ? 5'b00010 : 5'b00000;
        n_cmp++;
        if (obs !== want) begin n_bad++; $display("FAIL withdraw_ctl v=%0d c=%0d: got %b want %b", v, c, obs, want); end
        if (c == 2) begin
          n_cmp++;
          if (irq_id !== exp_id) begin n_bad++; $display("FAIL withdraw_id v=%0d: got %0d want %0d", v, irq_id, exp_id); end
          n_cmp++;
          if (serviced !== CB'(exp_serv)) begin n_bad++; $display("FAIL withdraw_serviced v=%0d: got %0d want %0d", v, serviced, CB'(exp_serv)); end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_done_ignored();
    logic [4:0] tbl [12];
    logic [4:0] obs;
    tbl = '{5'b00000, 5'b10010, 5'b01010, 5'b01010, 5'b00010, 5'b00010,
            5'b00010, 5'b00010, 5'b00110, 5'b00010, 5'b00010, 5'b00000};
    for (int c = 0; c <= 11; c++) begin
      ireq = (c <= 1); id = (c <= 1) ? 3'd6 : 3'd0;
      irq_ready = (c == 3); done = (c == 2 || c == 3 || c == 7);
      @(negedge clk);
      obs = {claim, irq_valid, complete, busy, timeout};
      n_cmp++;
      if (obs !== tbl[c]) begin n_bad++; $display("FAIL done_ignored c=%0d: got %b want %b", c, obs, tbl[c]); end
      @(posedge clk); #1;
    end
    exp_id = 3'd6; exp_serv++;
    n_cmp++;
    if (serviced !== CB'(exp_serv)) begin n_bad++; $display("FAIL done_ignored_serviced: got %0d want %0d", serviced, CB'(exp_serv)); end
  endtask

  // random ready/done latency with garbage ireq/id/done wherever they must be ignored
  task automatic test_random();
    int r, d, comp, len, es;
    logic [2:0] nid, eid;
    logic [4:0] obs, want;
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(3, 0);
      d = $urandom_range(5, 1);
      nid = 3'($urandom_range(7, 1));
      comp = 3 + r + d;
      len = comp + 1 + H;
      for (int t = 0; t <= len; t++) begin
        if (t <= 1) begin ireq = 1'b1; id = nid; end
        else if (t == len) begin ireq = 1'b0; id = 3'($urandom); end
        else begin ireq = 1'($urandom); id = 3'($urandom); end
        if (t == 2 + r) irq_ready = 1'b1;
        else if (t >= 2 && t < 2 + r) irq_ready = 1'b0;
        else irq_ready = 1'($urandom);
        if (t == comp - 1) done = 1'b1;
        else if (t > 2 + r && t < comp - 1) done = 1'b0;
        else done = 1'($urandom);
        want = {t == 1, t >= 2 && t <= 2 + r, t == comp, t >= 1 && t < len, 1'b0};
        eid  = (t >= 2) ? nid : exp_id;
        es   = (t > comp) ? exp_serv + 1 : exp_serv;
        @(negedge clk);
        obs = {claim, irq_valid, complete, busy, timeout};
        n_cmp++;
        if (obs !== want) begin n_bad++; $display("FAIL random_ctl n=%0d t=%0d r=%0d d=%0d: got %b want %b", n, t, r, d, obs, want); end
        n_cmp++;
        if (irq_id !== eid) begin n_bad++; $display("FAIL random_id n=%0d t=%0d: got %0d want %0d", n, t, irq_id, eid); end
        n_cmp++;
        if (serviced !== CB'(es)) begin n_bad++; $display("FAIL random_serviced n=%0d t=%0d: got %0d want %0d", n, t, serviced, CB'(es)); end
        @(posedge clk); #1;
      end
      exp_id = nid; exp_serv++;
    end
  endtask

  task automatic test_timeout();
    int npass, done_at, comp, len, es;
    logic tmo;
    logic [4:0] obs, want;
`ifdef PLIC_CLAIM_TIMEOUT_EN
    npass = 2;
`else
    npass = 1;
`endif
    for (int p = 0; p < npass; p++) begin
`ifdef PLIC_CLAIM_TIMEOUT_EN
      // SERVICE entered at t=3; limit reached at 3+TO-1, so completion lands at 3+TO
      done_at = (p == 1) ? 2 + TO : -1;
      comp = 3 + TO;
      tmo = (p == 0);
`else
      done_at = 113;
      comp = 114;
      tmo = 1'b0;
`endif
      len = comp + 1 + H;
      for (int t = 0; t <= len; t++) begin
        ireq = (t <= 1); id = (t <= 1) ? 3'd4 : 3'd0;
        irq_ready = (t == 2); done = (t == done_at);
        want = {t == 1, t == 2, t == comp, t >= 1 && t < len, tmo && t == comp};
        es = (t > comp) ? exp_serv + 1 : exp_serv;
        @(negedge clk);
        obs = {claim, irq_valid, complete, busy, timeout};
        n_cmp++;
        if (obs !== want) begin n_bad++; $display("FAIL timeout_ctl p=%0d t=%0d: got %b want %b", p, t, obs, want); end
        n_cmp++;
        if (serviced !== CB'(es)) begin n_bad++; $display("FAIL timeout_serviced p=%0d t=%0d: got %0d want %0d", p, t, serviced, CB'(es)); end
        @(posedge clk); #1;
      end
      exp_id = 3'd4; exp_serv++;
    end
  endtask

  task automatic test_wrap();
    logic [4:0] obs;
    while ((exp_serv % (1 << CB)) != (1 << CB) - 1) begin
      for (int c = 0; c <= 7; c++) begin
        ireq = (c <= 1); id = 3'd1; irq_ready = (c == 2); done = (c == 3);
        @(posedge clk); #1;
      end
      exp_id = 3'd1; exp_serv++;
    end
    ireq = 1'b0; id = 3'd0; irq_ready = 1'b0; done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (serviced !== CB'((1 << CB) - 1)) begin n_bad++; $display("FAIL wrap_preset: got %0d want %0d", serviced, (1 << CB) - 1); end
    @(posedge clk); #1;
    for (int c = 0; c <= 7; c++) begin
      ireq = (c <= 1); id = 3'd2; irq_ready = (c == 2); done = (c == 3);
      @(negedge clk);
      obs = {claim, irq_valid, complete, busy, timeout};
      if (c == 4) begin
        n_cmp++;
        if (obs !== 5'b00110) begin n_bad++; $display("FAIL wrap_complete: got %b want 00110", obs); end
      end
      if (c == 7) begin
        n_cmp++;
        if (serviced !== '0) begin n_bad++; $display("FAIL wrap_serviced: got %0d want 0", serviced); end
        n_cmp++;
        if (obs !== 5'b00000) begin n_bad++; $display("FAIL wrap_idle: got %b want 00000", obs); end
      end
      @(posedge clk); #1;
    end
    exp_id = 3'd2; exp_serv++;
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    for (int c = 0; c <= 5; c++) begin
      ireq = (c <= 1); id = (c <= 1) ? 3'd2 : 3'd0; irq_ready = (c == 2); done = 1'b0;
      @(negedge clk);
      if (c == 5) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_in_service: got busy=%b want 1", busy); end
        #2 rst_n = 1'b0;
        ireq = 1'b1; id = 3'd7; irq_ready = 1'b1; done = 1'b1;
        #1;
        obs = {claim, irq_valid, complete, busy, timeout};
        n_cmp++;
        if (obs !== 5'b0) begin n_bad++; $display("FAIL mid_async_outputs: got %b want 00000", obs); end
        n_cmp++;
        if (irq_id !== 3'd0) begin n_bad++; $display("FAIL mid_async_id: got %0d want 0", irq_id); end
        n_cmp++;
        if (serviced !== '0) begin n_bad++; $display("FAIL mid_async_serviced: got %0d want 0", serviced); end
      end else begin
        @(posedge clk); #1;
      end
    end
    exp_serv = 0; exp_id = 3'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      obs = {claim, irq_valid, complete, busy, timeout};
      n_cmp++;
      if (obs !== 5'b0) begin n_bad++; $display("FAIL mid_held_reset c=%0d: got %b want 00000", c, obs); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ireq = 1'b0; id = 3'd0; irq_ready = 1'b0; done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs = {claim, irq_valid, complete, busy, timeout};
      n_cmp++;
      if (obs !== 5'b0) begin n_bad++; $display("FAIL mid_after_release c=%0d: got %b want 00000", c, obs); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_withdraw();
    test_done_ignored();
    test_random();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
